sum_server: RTL and testbench

SUM_SERVER -- requirements
Module: sum_server

---
 rtl/sum_server_pkg.sv | 18 +
 rtl/sum_server_rr_arb2.sv | 41 ++++
 rtl/sum_server.sv | 108 ++++++++++
 tb/tb_sum_server.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sum_server_pkg.sv
// Shared port identifiers and default sizes for the two-port sum server.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sum_server_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/sum_server_rr_arb2.sv
// Two-request round-robin arbiter: one-hot grants plus per-port eligibility.
// Latency: grants are combinational; the pointer moves on the edge after an advance.
// Backpressure: none of its own; the caller qualifies eligibility with its own readiness.
module rr_arb2
    import sum_server_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic elig_a,
    output logic elig_b,
    output logic gnt_a,
    output logic gnt_b
);

    port_e rr_ptr_q;
    port_e rr_ptr_d;

    always_comb begin
        // A port is eligible unless the other one is also requesting and the pointer favours it.
        elig_a   = !req_b || (rr_ptr_q == PORT_A);
        elig_b   = !req_a || (rr_ptr_q == PORT_B);
        gnt_a    = req_a && elig_a;
        gnt_b    = req_b && elig_b;
        rr_ptr_d = rr_ptr_q;
        if (advance && req_a && req_b) begin
            rr_ptr_d = other_port(gnt_a ? PORT_A : PORT_B);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= PORT_A;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/sum_server.sv
// Two-port add server: arbitrates calls on A/B, returns op1+op2 with carry; SUM_SERVER_SAT_EN clamps on carry.
// Latency: result is valid one cycle after acceptance; full throughput back-to-back.
// Backpressure: a call is accepted only while the result register is empty or draining this cycle.
module sum_server
    import sum_server_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_op1,
    input  logic [WIDTH-1:0] a_op2,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_op1,
    input  logic [WIDTH-1:0] b_op2,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_port,
    output logic             resp_ovf,
    output logic [CNT_W-1:0] served_count
);

    logic             elig_a, elig_b, gnt_a, gnt_b;
    logic             can_accept, accept;
    logic [WIDTH-1:0] op1, op2;
    logic [WIDTH:0]   full_sum;

    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
    port_e            resp_port_q, resp_port_d;
    logic             resp_ovf_q, resp_ovf_d;
    logic [CNT_W-1:0] served_count_q, served_count_d;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .advance (accept),
        .elig_a  (elig_a),
        .elig_b  (elig_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    always_comb begin
        can_accept = !resp_valid_q || resp_ready;
        // Readies are held low throughout reset, not just until the first edge.
        a_ready    = reset_n && can_accept && elig_a;
        b_ready    = reset_n && can_accept && elig_b;
        accept     = (a_valid && a_ready) || (b_valid && b_ready);

        op1        = gnt_a ? a_op1 : b_op1;
        op2        = gnt_a ? a_op2 : b_op2;
        full_sum   = {1'b0, op1} + {1'b0, op2};

        resp_valid_d   = resp_valid_q;
        resp_sum_d     = resp_sum_q;
        resp_port_d    = resp_port_q;
        resp_ovf_d     = resp_ovf_q;
        served_count_d = served_count_q;

        if (resp_valid_q && resp_ready) begin
            served_count_d = served_count_q + 1'b1;
        end

        if (accept) begin
            resp_valid_d = 1'b1;
            resp_ovf_d   = full_sum[WIDTH];
            resp_port_d  = gnt_b ? PORT_B : PORT_A;
`ifdef SUM_SERVER_SAT_EN
            resp_sum_d   = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
            resp_sum_d   = full_sum[WIDTH-1:0];
`endif
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q   <= 1'b0;
            resp_sum_q     <= '0;
            resp_port_q    <= PORT_A;
            resp_ovf_q     <= 1'b0;
            served_count_q <= '0;
        end else begin
            resp_valid_q   <= resp_valid_d;
            resp_sum_q     <= resp_sum_d;
            resp_port_q    <= resp_port_d;
            resp_ovf_q     <= resp_ovf_d;
            served_count_q <= served_count_d;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_sum     = resp_sum_q;
    assign resp_port    = resp_port_q;
    assign resp_ovf     = resp_ovf_q;
    assign served_count = served_count_q;

endmodule

// File: tb/tb_sum_server.sv
// Randomised and directed bench for sum_server against a transaction-level model.
// Latency: n/a. Backpressure: resp_ready is driven randomly and in directed stalls.
module tb_sum_server;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [W-1:0]  a_op1, a_op2, b_op1, b_op2;
    logic          resp_valid, resp_ready, resp_port, resp_ovf;
    logic [W-1:0]  resp_sum;
    logic [CW-1:0] served_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: the pending result and counters
    bit m_vld;
    int m_sum, m_port, m_ovf, m_cnt, m_ptr;

    always #5 clock = ~clock;

    sum_server #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_op1        (a_op1),
        .a_op2        (a_op2),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_op1        (b_op1),
        .b_op2        (b_op2),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_sum     (resp_sum),
        .resp_port    (resp_port),
        .resp_ovf     (resp_ovf),
        .served_count (served_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Asserts reset away from a clock edge, checks it takes effect at once, releases on a negedge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_vld", {31'd0, resp_valid}, 0);
        chk("rst_sum", {24'd0, resp_sum}, 0);
        chk("rst_port", {31'd0, resp_port}, 0);
        chk("rst_ovf", {31'd0, resp_ovf}, 0);
        chk("rst_cnt", {28'd0, served_count}, 0);
        chk("rst_ardy", {31'd0, a_ready}, 0);
        chk("rst_brdy", {31'd0, b_ready}, 0);
        m_vld = 0; m_sum = 0; m_port = 0; m_ovf = 0; m_cnt = 0; m_ptr = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic step(input bit av, input int a1, input int a2,
                        input bit bv, input int b1, input int b2, input bit rr);
        bit can, acc;
        int g, s;
        a_valid = av; a_op1 = a1[W-1:0]; a_op2 = a2[W-1:0];
        b_valid = bv; b_op1 = b1[W-1:0]; b_op2 = b2[W-1:0];
        resp_ready = rr;
        #1;
        can = !m_vld || rr;
        chk("a_ready", {31'd0, a_ready}, {31'd0, can && (!bv || m_ptr == 0)});
        chk("b_ready", {31'd0, b_ready}, {31'd0, can && (!av || m_ptr == 1)});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_vld});
        if (m_vld) begin
            chk("resp_sum", {24'd0, resp_sum}, m_sum);
            chk("resp_port", {31'd0, resp_port}, m_port);
            chk("resp_ovf", {31'd0, resp_ovf}, m_ovf);
        end
        chk("served_count", {28'd0, served_count}, m_cnt);
        @(posedge clock);
        g   = (av && bv) ? m_ptr : (av ? 0 : 1);
        acc = can && (av || bv);
        if (m_vld && rr) m_cnt = (m_cnt + 1) % (1 << CW);
        if (acc) begin
            s = (g == 0) ? (a1 % 256) + (a2 % 256) : (b1 % 256) + (b2 % 256);
            m_ovf = (s > 255) ? 1 : 0;
`ifdef SUM_SERVER_SAT_EN
            m_sum = (s > 255) ? 255 : s;
`else
            m_sum = s % 256;
`endif
            m_port = g;
            m_vld  = 1;
            if (av && bv) m_ptr = 1 - g;
        end else if (rr) begin
            m_vld = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = 0; b_valid = 0; resp_ready = 0;
        a_op1 = 0; a_op2 = 0; b_op1 = 0; b_op2 = 0;
        do_reset();

        // Single call on A
        step(1, 3, 4, 0, 0, 0, 1);
        chk("first_sum", {24'd0, resp_sum}, 7);
        chk("first_port", {31'd0, resp_port}, 0);
        step(0, 9, 9, 0, 0, 0, 1);

        // Both ports contending: ports must alternate starting at A
        do_reset();
        for (int i = 0; i < 4; i++) step(1, i, 1, 1, i, 2, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rr_count4", {28'd0, served_count}, 4);

        // Stall with a pending result, then drain and accept in one cycle
        do_reset();
        step(1, 10, 20, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 2, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 1);
        chk("b2b_vld", {31'd0, resp_valid}, 1);
        chk("b2b_sum", {24'd0, resp_sum}, 3);
        step(0, 0, 0, 0, 0, 0, 1);

        // Carry out of the add
        step(1, 200, 100, 0, 0, 0, 1);
        chk("ovf_flag", {31'd0, resp_ovf}, 1);
`ifdef SUM_SERVER_SAT_EN
        chk("ovf_sum", {24'd0, resp_sum}, 255);
`else
        chk("ovf_sum", {24'd0, resp_sum}, 44);
`endif

        // Reset mid-transaction with both valids high; pointer must return to A
        step(1, 5, 5, 0, 0, 0, 0);
        a_valid = 1; b_valid = 1;
        #2;
        do_reset();
        step(1, 1, 1, 1, 2, 2, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Counter wrap with a 4-bit counter after 17 consumed responses
        do_reset();
        for (int i = 0; i < 17; i++) step(1, i, i, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("cnt_wrap17", {28'd0, served_count}, 1);

        // Randomised traffic, operands on idle ports are still randomised
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
